// File: rtl/fir3_inverse_pkg.sv
// Shared definitions for the FIR(20,15,10) deconvolver: FSM encoding,
// default coefficients and residual-width derivation.
package fir3_inverse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 16;
    localparam int C0_DEF = 20;
    localparam int C1_DEF = 15;
    localparam int C2_DEF = 10;

    // Signed residual width: y plus a sign bit plus one guard bit.
    localparam int RW = YW_DEF + 2;

    function automatic int rw_of(input int yw);
        return yw + 2;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider by a constant, one quotient bit per clock, MSB first.
// done_o marks the cycle whose closing edge performs the final step.
module seq_divider #(
    parameter int NW      = 17,
    parameter int DIVISOR = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] quot_o,
    output logic [NW:0]   rem_o
);

    localparam int CW = $clog2(NW + 1);
    localparam logic [NW:0] DIV_W = (NW + 1)'(DIVISOR);

    logic [NW-1:0] dvd_q, dvd_d;
    logic [NW-1:0] quot_q, quot_d;
    logic [NW:0]   rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [NW:0]   rem_shift;
    logic          ge;

    assign rem_shift = {rem_q[NW-1:0], dvd_q[NW-1]};
    assign ge        = (rem_shift >= DIV_W);
    assign done_o    = busy_q && (cnt_q == CW'(NW - 1));

    always_comb begin
        dvd_d  = dvd_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            dvd_d  = dividend_i;
            quot_d = '0;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? (rem_shift - DIV_W) : rem_shift;
            quot_d = {quot_q[NW-2:0], ge};
            dvd_d  = dvd_q << 1;
            cnt_d  = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/fir3_inverse.sv
// Recovers x[k] from y[k] = C0*x[k] + C1*x[k-1] + C2*x[k-2] by residual
// subtraction followed by a multi-cycle divide by C0, with clamping to XW bits.
module fir3_inverse
    import fir3_inverse_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int C0 = C0_DEF,
    parameter int C1 = C1_DEF,
    parameter int C2 = C2_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [YW-1:0] y_in,
    input  logic          y_valid,
    output logic          y_ready,
    output logic [XW-1:0] x_out,
    output logic          x_valid,
    output logic          err
);

    localparam int RWL = rw_of(YW);
    localparam int NW  = YW + 1;

    state_e state_q, state_d;

    logic [YW-1:0] y_reg_q, y_reg_d;
    logic [XW-1:0] x1_q, x1_d;
    logic [XW-1:0] x2_q, x2_d;
    logic [XW-1:0] x_out_q, x_out_d;
    logic          neg_q, neg_d;
    logic          x_valid_q, x_valid_d;
    logic          err_q, err_d;

    logic [RWL-1:0]        y_ext, prod1, prod2;
    logic signed [RWL-1:0] resid;
    logic [NW-1:0]         mag;

    logic          div_start, div_busy, div_done;
    logic [NW-1:0] quot;
    logic [NW:0]   rem;

    logic [XW-1:0] xk;
    logic          xk_err;

    // Products are formed at full residual width so no term truncates.
    always_comb begin
        y_ext = RWL'(y_reg_q);
        prod1 = RWL'(C1) * RWL'(x1_q);
        prod2 = RWL'(C2) * RWL'(x2_q);
        resid = $signed(y_ext) - $signed(prod1) - $signed(prod2);
        mag   = resid[RWL-1] ? NW'(-resid) : NW'(resid);
    end

    always_comb begin
        xk     = quot[XW-1:0];
        xk_err = (rem != '0);
        if (neg_q) begin
            xk     = '0;
            xk_err = 1'b1;
        end else if (quot[NW-1:XW] != '0) begin
            xk     = '1;
            xk_err = 1'b1;
        end
    end

    seq_divider #(
        .NW      (NW),
        .DIVISOR (C0)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (mag),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        state_d   = state_q;
        y_reg_d   = y_reg_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        neg_d     = neg_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        err_d     = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    x1_d = '0;
                    x2_d = '0;
                end else if (y_valid) begin
                    y_reg_d = y_in;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                neg_d     = resid[RWL-1];
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_busy && div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The clamped value, not the raw quotient, feeds the history.
                x_out_d   = xk;
                x_valid_d = 1'b1;
                err_d     = xk_err;
                x2_d      = x1_q;
                x1_d      = xk;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            y_reg_q   <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            neg_q     <= 1'b0;
            x_out_q   <= '0;
            x_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_reg_q   <= y_reg_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            neg_q     <= neg_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            err_q     <= err_d;
        end
    end

    assign y_ready = (state_q == ST_IDLE);
    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign err     = err_q;

endmodule
